ddr4_cmd_sequencer: RTL and testbench
=====================================

# ddr4_cmd_sequencer

Single-rank DDR4 command sequencer, closed-page, one request in flight. Accepts read/write requests on a valid/ready handshake and drives the DDR4 command/address pins of `DDR4_if` with ACT → RDA/WRA sequences. Also runs power-up CKE sequencing and periodic refresh with postponement tracking. Sits between the testbench traffic generator (or a future multi-port arbiter) and the DRAM model; the DQ/DQS datapath is owned elsewhere and aligned via the `rd_issue`/`wr_issue` pulses. Controller clock runs 1:1 with tCK; all timing parameters are in clock cycles.

## Interface
- T_INIT, 10: cycles CKE held low after reset release
- T_RCD, 4: cycles from ACT to RDA/WRA
- T_RC, 12: minimum cycles from ACT to next ACT or REF
- T_CLOSE, 8: minimum cycles from RDA/WRA to next ACT or REF; covers auto-precharge plus tRP
- T_REFI, 100: refresh interval
- T_RFC, 20: cycles from REF to next command
- ROW_BITS, 18; COL_BITS, 10
- Widths of BG, BA and C come from `arch_package` constants MAX_BANK_GROUP_BITS, MAX_BANK_BITS and MAX_RANK_BITS.

Ports:
- CLK  in  1  controller clock; one clock, rising edge
- RESET_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_bg / req_ba  in  MAX_BANK_GROUP_BITS / MAX_BANK_BITS  target bank group / bank
- req_row  in  ROW_BITS  row address
- req_col  in  COL_BITS  column address (BL8-aligned)
- CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  DDR4 command pins
- BG, BA, C, ADDR[13:0], ADDR_17  out  per arch_package  DDR4 address pins
- rd_issue / wr_issue  out  1  one-cycle pulse, coincident with RDA / WRA on the pins
- ref_overflow  out  1  sticky flag: refresh debt exceeded 8
- busy  out  1  state != IDLE

## Operation
- All pin outputs are registered.
- Reset values: CKE=0, CS_n=ACT_n=RAS_n_A16=CAS_n_A15=WE_n_A14=1, BG=BA=C=ADDR=ADDR_17=0, req_ready=0, rd_issue=wr_issue=0, ref_overflow=0, busy=1.
- States:
  - INIT: count T_INIT cycles, then drive CKE=1 and go to IDLE.
  - IDLE: from here, REF is chosen if refresh is owed, otherwise ACT if a request is accepted.
  - ACT: issue ACT.
  - WAIT_RCD: wait for T_RCD.
  - CAS: issue RDA or WRA.
  - REF: issue REF.
  - WAIT_RFC: wait T_RFC, then return to IDLE.
- Commands use CS_n=0; every other cycle is DES (CS_n=1, ACT_n/RAS/CAS/WE=1, address pins 0).
  - ACT: ACT_n=0; {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR} = row.
  - RDA: ACT_n=1, RAS/CAS/WE = H,L,H; ADDR[9:0]=col, ADDR[10]=1 (auto-precharge), ADDR[12]=1 (BL8).
  - WRA: same as RDA but RAS/CAS/WE = H,L,L.
  - REF: RAS/CAS/WE = L,L,H; ADDR=0.
  - C=0 always.
- Counters:
  - rc_cnt loads T_RC-1 on ACT.
  - close_cnt loads T_CLOSE-1 on CAS and T_RFC-1 on REF.
  - Both count down to 0 and saturate there.
- Refresh accounting:
  - refi_cnt starts when CKE rises. Each time it reaches T_REFI, ref_debt increments, saturating at 8.
  - An expiry while ref_debt is already 8 sets ref_overflow.
  - Issuing REF decrements ref_debt. An expiry and a REF issue in the same cycle leave ref_debt unchanged.
- req_ready = (state==IDLE) && rc_cnt==0 && close_cnt==0 && ref_debt==0.
  - Refresh strictly preempts new requests.
  - The request fields are latched on acceptance.
- Reset asserted mid-sequence: return to reset values immediately and restart from INIT. The DRAM RESET_n pin is not driven by this block.

## Timing
- Request accepted at edge N → ACT on the pins during cycle N+1.
- RDA/WRA on the pins exactly T_RCD cycles after ACT; rd_issue or wr_issue pulses in that same cycle.
- Next ACT no earlier than max(ACT+T_RC, CAS+T_CLOSE).
- REF follows the same bound, plus T_RFC before any further command.
- With continuous back-to-back requests and default parameters: ACT-to-ACT = max(12, 4+8) = 12 cycles.
- In IDLE with debt > 0 and both counters at 0, REF appears on the pins the next cycle.

## Structure
- `ddr4_ctrl_pkg` holds:
  - the state enum;
  - the command enum {DES, ACT, RDA, WRA, REF};
  - a function mapping a command to {CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
  - constants MAX_REF_DEBT=8 and the A10 (auto-precharge) and A12 (BL8) bit indices.
- Sub-module `ddr4_refresh_timer` owns refi_cnt, ref_debt and ref_overflow. Its interface is: enable (CKE high), ref_done pulse in, ref_pending out.

## Test plan
- Reset, then idle: CKE low for 10 cycles, then high; all pins stay DES. req_ready rises once the state is IDLE.
- Single read (bg=1, ba=2, row=0x2A5A5, col=0x3F8) accepted at cycle N:
  - ACT at N+1 with ADDR_17=1, RAS=0, CAS=1, WE=0, ADDR=0x25A5;
  - RDA at N+5 with ADDR=0x17F8; rd_issue high in that cycle only.
- Two back-to-back writes: second ACT exactly 12 cycles after the first; wr_issue pulses 4 cycles after each ACT.
- Refresh during traffic: with T_REFI=100, REF issued after the in-flight request closes; req_ready stays low during that time; the next ACT comes no earlier than REF+20.
- Debt overflow: hold a request sequence artificially via T_REFI=5 with T_RFC=20. ref_debt saturates at 8, then ref_overflow sets and stays set until reset.
- Reset asserted 2 cycles after ACT: outputs return to reset values asynchronously, no RDA appears, and the INIT sequence restarts.

Source files
------------

// File: rtl/arch_package.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arch_package : DDR4 device address-width constants (x8, single rank)  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package arch_package;
    localparam int MAX_BANK_GROUP_BITS = 2;
    localparam int MAX_BANK_BITS       = 2;
    localparam int MAX_RANK_BITS       = 1;
endpackage
`default_nettype wire

// File: rtl/ddr4_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr4_ctrl_pkg : sequencer states, DDR4 commands and pin encoding      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ddr4_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_REF, ST_WAIT_RFC
    } state_t;

    typedef enum logic [2:0] {
        CMD_DES, CMD_ACT, CMD_RDA, CMD_WRA, CMD_REF
    } cmd_t;

    localparam int MAX_REF_DEBT = 8;
    localparam int A10_AP       = 10;
    localparam int A12_BL8      = 12;

    // Returns {CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14}; for ACT the low
    // three bits are placeholders that the caller replaces with row bits.
    function automatic logic [4:0] cmd_pins(input cmd_t cmd);
        case (cmd)
            CMD_ACT: cmd_pins = 5'b00111;
            CMD_RDA: cmd_pins = 5'b01101;
            CMD_WRA: cmd_pins = 5'b01100;
            CMD_REF: cmd_pins = 5'b01001;
            default: cmd_pins = 5'b11111;
        endcase
    endfunction
endpackage
`default_nettype wire

// File: rtl/ddr4_refresh_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr4_refresh_timer : tREFI interval counter and refresh debt tracking |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ddr4_refresh_timer
    import ddr4_ctrl_pkg::*;
#(
    parameter int T_REFI = 100
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic enable,
    input  logic ref_done,
    output logic ref_pending,
    output logic ref_overflow
);
    localparam int REFI_W = ($clog2(T_REFI) > 0) ? $clog2(T_REFI) : 1;
    localparam int DEBT_W = $clog2(MAX_REF_DEBT + 1);

    logic [REFI_W-1:0] refi_cnt;
    logic [DEBT_W-1:0] ref_debt;
    logic              expire;

    assign expire      = enable && (refi_cnt == REFI_W'(T_REFI - 1));
    assign ref_pending = (ref_debt != '0);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            refi_cnt     <= '0;
            ref_debt     <= '0;
            ref_overflow <= 1'b0;
        end else begin
            if (!enable || expire) begin
                refi_cnt <= '0;
            end else begin
                refi_cnt <= refi_cnt + 1'b1;
            end
            // A REF landing on the same edge as an expiry cancels it out.
            if (expire && !ref_done) begin
                if (ref_debt == DEBT_W'(MAX_REF_DEBT)) begin
                    ref_overflow <= 1'b1;
                end else begin
                    ref_debt <= ref_debt + 1'b1;
                end
            end else if (ref_done && !expire && (ref_debt != '0)) begin
                ref_debt <= ref_debt - 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ddr4_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr4_cmd_sequencer : closed-page DDR4 ACT->RDA/WRA/REF sequencer      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ddr4_cmd_sequencer
    import arch_package::*;
    import ddr4_ctrl_pkg::*;
#(
    parameter int T_INIT   = 10,
    parameter int T_RCD    = 4,
    parameter int T_RC     = 12,
    parameter int T_CLOSE  = 8,
    parameter int T_REFI   = 100,
    parameter int T_RFC    = 20,
    parameter int ROW_BITS = 18,
    parameter int COL_BITS = 10
) (
    input  logic                           CLK,
    input  logic                           RESET_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [MAX_BANK_GROUP_BITS-1:0] req_bg,
    input  logic [MAX_BANK_BITS-1:0]       req_ba,
    input  logic [ROW_BITS-1:0]            req_row,
    input  logic [COL_BITS-1:0]            req_col,
    output logic                           CKE,
    output logic                           CS_n,
    output logic                           ACT_n,
    output logic                           RAS_n_A16,
    output logic                           CAS_n_A15,
    output logic                           WE_n_A14,
    output logic [MAX_BANK_GROUP_BITS-1:0] BG,
    output logic [MAX_BANK_BITS-1:0]       BA,
    output logic [MAX_RANK_BITS-1:0]       C,
    output logic [13:0]                    ADDR,
    output logic                           ADDR_17,
    output logic                           rd_issue,
    output logic                           wr_issue,
    output logic                           ref_overflow,
    output logic                           busy
);
    localparam int WAIT_MAX = (T_INIT > T_RCD) ? T_INIT : T_RCD;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int RC_W     = ($clog2(T_RC) > 0) ? $clog2(T_RC) : 1;
    localparam int CL_MAX   = (T_CLOSE > T_RFC) ? T_CLOSE : T_RFC;
    localparam int CL_W     = ($clog2(CL_MAX) > 0) ? $clog2(CL_MAX) : 1;

    state_t                         state, next_state;
    cmd_t                           cmd_d;
    logic [WAIT_W-1:0]              wait_cnt;
    logic [RC_W-1:0]                rc_cnt;
    logic [CL_W-1:0]                close_cnt;
    logic                           timers_clear;
    logic                           accept;
    logic                           ref_pending;
    logic                           ref_done;

    logic                           lat_write;
    logic [MAX_BANK_GROUP_BITS-1:0] lat_bg;
    logic [MAX_BANK_BITS-1:0]       lat_ba;
    logic [COL_BITS-1:0]            lat_col;

    logic [4:0]                     pins_d;
    logic [MAX_BANK_GROUP_BITS-1:0] bg_d;
    logic [MAX_BANK_BITS-1:0]       ba_d;
    logic [13:0]                    addr_d;
    logic                           addr_17_d;

    assign timers_clear = (rc_cnt == '0) && (close_cnt == '0);
    assign req_ready    = (state == ST_IDLE) && timers_clear && !ref_pending;
    assign accept       = req_valid && req_ready;
    assign busy         = (state != ST_IDLE);
    assign ref_done     = (next_state == ST_REF);

    ddr4_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .enable       (CKE),
        .ref_done     (ref_done),
        .ref_pending  (ref_pending),
        .ref_overflow (ref_overflow)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // WAIT_RCD is entered one cycle after ACT, so it lasts T_RCD-1 cycles.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:     if (wait_cnt == WAIT_W'(T_INIT - 1)) next_state = ST_IDLE;
            ST_IDLE: begin
                if (timers_clear && ref_pending) begin
                    next_state = ST_REF;
                end else if (accept) begin
                    next_state = ST_ACT;
                end
            end
            ST_ACT:      next_state = ST_WAIT_RCD;
            ST_WAIT_RCD: if (wait_cnt == WAIT_W'(T_RCD - 2)) next_state = ST_CAS;
            ST_CAS:      next_state = ST_IDLE;
            ST_REF:      next_state = ST_WAIT_RFC;
            ST_WAIT_RFC: if (close_cnt == '0) next_state = ST_IDLE;
            default:     next_state = ST_INIT;
        endcase
    end

    // Pin values are derived from the state being entered so they register
    // onto the bus in the same cycle the state register shows that state.
    always_comb begin
        case (next_state)
            ST_ACT:  cmd_d = CMD_ACT;
            ST_CAS:  cmd_d = lat_write ? CMD_WRA : CMD_RDA;
            ST_REF:  cmd_d = CMD_REF;
            default: cmd_d = CMD_DES;
        endcase
        pins_d    = cmd_pins(cmd_d);
        bg_d      = '0;
        ba_d      = '0;
        addr_d    = '0;
        addr_17_d = 1'b0;
        if (cmd_d == CMD_ACT) begin
            {addr_17_d, pins_d[2:0], addr_d} = 18'(req_row);
            bg_d = req_bg;
            ba_d = req_ba;
        end else if (cmd_d == CMD_RDA || cmd_d == CMD_WRA) begin
            addr_d          = 14'(lat_col);
            addr_d[A10_AP]  = 1'b1;
            addr_d[A12_BL8] = 1'b1;
            bg_d            = lat_bg;
            ba_d            = lat_ba;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wait_cnt  <= '0;
            rc_cnt    <= '0;
            close_cnt <= '0;
            lat_write <= 1'b0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_col   <= '0;
        end else begin
            wait_cnt <= (next_state != state) ? '0 : wait_cnt + 1'b1;
            if (next_state == ST_ACT) begin
                rc_cnt <= RC_W'(T_RC - 1);
            end else if (rc_cnt != '0) begin
                rc_cnt <= rc_cnt - 1'b1;
            end
            if (next_state == ST_CAS) begin
                close_cnt <= CL_W'(T_CLOSE - 1);
            end else if (next_state == ST_REF) begin
                close_cnt <= CL_W'(T_RFC - 1);
            end else if (close_cnt != '0) begin
                close_cnt <= close_cnt - 1'b1;
            end
            if (accept) begin
                lat_write <= req_write;
                lat_bg    <= req_bg;
                lat_ba    <= req_ba;
                lat_col   <= req_col;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            CKE                                         <= 1'b0;
            {CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'b11111;
            BG                                          <= '0;
            BA                                          <= '0;
            C                                           <= '0;
            ADDR                                        <= '0;
            ADDR_17                                     <= 1'b0;
            rd_issue                                    <= 1'b0;
            wr_issue                                    <= 1'b0;
        end else begin
            CKE                                         <= (next_state != ST_INIT);
            {CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= pins_d;
            BG                                          <= bg_d;
            BA                                          <= ba_d;
            C                                           <= '0;
            ADDR                                        <= addr_d;
            ADDR_17                                     <= addr_17_d;
            rd_issue                                    <= (cmd_d == CMD_RDA);
            wr_issue                                    <= (cmd_d == CMD_WRA);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ddr4_cmd_sequencer : scoreboard bench for the DDR4 cmd sequencer   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ddr4_cmd_sequencer;
    import arch_package::*;

    localparam int T_INIT = 10;
    localparam int T_RCD  = 4;
    localparam int T_RC   = 12;
    localparam int T_CLOSE = 8;
    localparam int T_RFC  = 20;

    localparam logic [25:0] DES_VEC = {5'b11111, 21'b0};
    localparam logic [25:0] REF_VEC = {5'b01001, 21'b0};

    typedef struct {
        int          cyc;
        logic [25:0] pins;
    } exp_t;

    typedef struct {
        logic        w;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [17:0] row;
        logic [9:0]  col;
    } req_t;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_write = 1'b0;
    logic [MAX_BANK_GROUP_BITS-1:0] req_bg = '0;
    logic [MAX_BANK_BITS-1:0]       req_ba = '0;
    logic [17:0] req_row = '0;
    logic [9:0]  req_col = '0;

    wire req_ready, CKE, CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    wire [MAX_BANK_GROUP_BITS-1:0] BG;
    wire [MAX_BANK_BITS-1:0]       BA;
    wire [MAX_RANK_BITS-1:0]       C;
    wire [13:0] ADDR;
    wire ADDR_17, rd_issue, wr_issue, ref_overflow, busy;

    wire o_ready, o_cke, o_cs_n, o_act_n, o_ras, o_cas, o_we;
    wire [MAX_BANK_GROUP_BITS-1:0] o_bg;
    wire [MAX_BANK_BITS-1:0]       o_ba;
    wire [MAX_RANK_BITS-1:0]       o_c;
    wire [13:0] o_addr;
    wire o_a17, o_rd, o_wr, o_ovf, o_busy;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_act = -1000, last_cas = -1000, last_ref = -1000;
    int   ref_count = 0;

    req_t tbl [9] = '{
        '{1'b0, 2'd0, 2'd0, 18'h00001, 10'h008},
        '{1'b1, 2'd3, 2'd3, 18'h3FFFF, 10'h3F8},
        '{1'b0, 2'd2, 2'd1, 18'h15555, 10'h100},
        '{1'b1, 2'd1, 2'd0, 18'h0ABCD, 10'h010},
        '{1'b0, 2'd3, 2'd2, 18'h20000, 10'h000},
        '{1'b1, 2'd0, 2'd3, 18'h1C0DE, 10'h2A8},
        '{1'b0, 2'd1, 2'd1, 18'h3000F, 10'h0F0},
        '{1'b1, 2'd2, 2'd2, 18'h12345, 10'h338},
        '{1'b0, 2'd0, 2'd1, 18'h2FFFF, 10'h3C0}
    };

    ddr4_cmd_sequencer dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .CKE(CKE), .CS_n(CS_n), .ACT_n(ACT_n), .RAS_n_A16(RAS_n_A16),
        .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .BG(BG), .BA(BA), .C(C), .ADDR(ADDR), .ADDR_17(ADDR_17),
        .rd_issue(rd_issue), .wr_issue(wr_issue),
        .ref_overflow(ref_overflow), .busy(busy)
    );

    // Refresh interval far shorter than tRFC, so debt can only grow.
    ddr4_cmd_sequencer #(.T_REFI(5), .T_RFC(20)) dut_ovf (
        .CLK(CLK), .RESET_n(RESET_n),
        .req_valid(1'b0), .req_ready(o_ready), .req_write(1'b0),
        .req_bg('0), .req_ba('0), .req_row('0), .req_col('0),
        .CKE(o_cke), .CS_n(o_cs_n), .ACT_n(o_act_n), .RAS_n_A16(o_ras),
        .CAS_n_A15(o_cas), .WE_n_A14(o_we),
        .BG(o_bg), .BA(o_ba), .C(o_c), .ADDR(o_addr), .ADDR_17(o_a17),
        .rd_issue(o_rd), .wr_issue(o_wr),
        .ref_overflow(o_ovf), .busy(o_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [25:0] pins_now();
        return {CS_n, ACT_n, RAS_n_A16, CAS_n_A15, WE_n_A14, BG, BA, ADDR_17, ADDR,
                rd_issue, wr_issue};
    endfunction

    function automatic logic [25:0] exp_act(input logic [1:0] bg, input logic [1:0] ba,
                                             input logic [17:0] row);
        return {1'b0, 1'b0, row[16], row[15], row[14], bg, ba, row[17], row[13:0], 2'b00};
    endfunction

    function automatic logic [25:0] exp_cas(input logic w, input logic [1:0] bg,
                                             input logic [1:0] ba, input logic [9:0] col);
        return {1'b0, 1'b1, 1'b1, 1'b0, ~w, bg, ba, 1'b0, 4'b0101, col, ~w, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RESET_n) begin
            last_act = -1000;
            last_cas = -1000;
            last_ref = -1000;
        end else begin
            chk("c_zero", C, 0);
            if (cyc >= last_ref && cyc < last_ref + T_RFC) chk("ready_in_rfc", req_ready, 0);
            if (!CS_n && ACT_n && !RAS_n_A16 && !CAS_n_A15 && WE_n_A14) begin
                chk("ref_pins", pins_now(), REF_VEC);
                chk("ref_after_act", (cyc - last_act) >= T_RC, 1);
                chk("ref_after_cas", (cyc - last_cas) >= T_CLOSE, 1);
                chk("ref_after_ref", (cyc - last_ref) >= T_RFC, 1);
                last_ref = cyc;
                ref_count++;
            end else if (!CS_n || rd_issue || wr_issue) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got pins %0h required none (cycle %0d)",
                             pins_now(), cyc);
                end else begin
                    e = q.pop_front();
                    chk("cmd_cycle", cyc, e.cyc);
                    chk("cmd_pins", pins_now(), e.pins);
                    if (!e.pins[24]) begin
                        chk("act_after_act", (cyc - last_act) >= T_RC, 1);
                        chk("act_after_cas", (cyc - last_cas) >= T_CLOSE, 1);
                        chk("act_after_ref", (cyc - last_ref) >= T_RFC, 1);
                        last_act = cyc;
                    end else begin
                        last_cas = cyc;
                    end
                end
            end else begin
                chk("des_pins", pins_now(), DES_VEC);
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_cke", CKE, 0);
        chk("rst_pins", pins_now(), DES_VEC);
        chk("rst_c", C, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ovf", ref_overflow, 0);
        chk("rst_ovf_inst_ovf", o_ovf, 0);
        chk("rst_ovf_inst_cke", o_cke, 0);
    endtask

    // Entered at the negedge on which reset was released.
    task automatic check_init();
        for (int k = 1; k <= T_INIT; k++) begin
            @(negedge CLK);
            chk("init_cke", CKE, (k >= T_INIT));
            chk("init_ready", req_ready, (k >= T_INIT));
            chk("init_busy", busy, (k < T_INIT));
        end
    endtask

    task automatic send(input logic w, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [17:0] row, input logic [9:0] col,
                        input logic [25:0] ea, input logic [25:0] ec, output int n);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_write = w;
        req_bg    = bg;
        req_ba    = ba;
        req_row   = row;
        req_col   = col;
        while (!req_ready && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            n = -1;
        end else begin
            n = cyc + 1;
            q.push_back('{n, ea});
            q.push_back('{n + T_RCD, ec});
            @(negedge CLK);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_queue", q.size(), 0);
    endtask

    initial begin : stim
        int n, n1, n2;
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values();
        RESET_n = 1'b1;
        check_init();
        chk("ovf_clear_early", o_ovf, 0);

        send(1'b0, 2'd1, 2'd2, 18'h2A5A5, 10'h3F8,
             {5'b00010, 2'b01, 2'b10, 1'b1, 14'h25A5, 2'b00},
             {5'b01101, 2'b01, 2'b10, 1'b0, 14'h17F8, 2'b10}, n);

        send(1'b1, 2'd2, 2'd1, 18'h0F0F0, 10'h048,
             exp_act(2'd2, 2'd1, 18'h0F0F0), exp_cas(1'b1, 2'd2, 2'd1, 10'h048), n1);
        send(1'b1, 2'd3, 2'd0, 18'h30303, 10'h200,
             exp_act(2'd3, 2'd0, 18'h30303), exp_cas(1'b1, 2'd3, 2'd0, 10'h200), n2);
        chk("b2b_act_spacing", n2 - n1, 12);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].w, tbl[i].bg, tbl[i].ba, tbl[i].row, tbl[i].col,
                 exp_act(tbl[i].bg, tbl[i].ba, tbl[i].row),
                 exp_cas(tbl[i].w, tbl[i].bg, tbl[i].ba, tbl[i].col), n);
        end
        drain();
        chk("ref_seen_in_traffic", (ref_count >= 1), 1);

        chk("ovf_set", o_ovf, 1);
        repeat (25) @(negedge CLK);
        chk("ovf_sticky", o_ovf, 1);

        send(1'b0, 2'd2, 2'd3, 18'h01234, 10'h1F0,
             exp_act(2'd2, 2'd3, 18'h01234), exp_cas(1'b0, 2'd2, 2'd3, 10'h1F0), n);
        while (n > 0 && cyc < n + 2) @(negedge CLK);
        #2;
        RESET_n = 1'b0;
        q.delete();
        #1;
        check_reset_values();
        repeat (4) @(negedge CLK);
        RESET_n = 1'b1;
        check_init();

        send(1'b1, 2'd3, 2'd0, 18'h2BEEF, 10'h158,
             exp_act(2'd3, 2'd0, 18'h2BEEF), exp_cas(1'b1, 2'd3, 2'd0, 10'h158), n);
        drain();
        chk("def_no_overflow", ref_overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end
endmodule
`default_nettype wire
